// File: rtl/down_timer.sv
// -----------------------------------------------------------------------------
// down_timer
//   Loadable down-counter/timer with a prescaler and an IDLE/ARMED/RUN/HOLD
//   control FSM. The count output feeds the zero-detect comparator directly.
//   done pulses for one cycle when the count reaches 0 under timer control.
//
// Optional feature: define DOWN_TIMER_RELOAD_EN to reload the count from the
//   last accepted load value at terminal count and keep running (periodic
//   mode). A reload value of 0 still returns to IDLE.
//
// Parameters
//   WIDTH    count/load width (comparator expects 16)
//   PRE_DIV  clk cycles per decrement tick, 1..65535
//
// Ports
//   clk         in   clock, all state on rising edge
//   rst         in   asynchronous active-high reset
//   load_valid  in   load request
//   load_ready  out  1 in IDLE/ARMED (combinational from state)
//   load_val    in   value captured on load_valid && load_ready
//   start       in   level, honoured only in ARMED
//   pause       in   level, freezes count and prescaler while running
//   abort       in   level, forces IDLE from any state
//   count       out  registered current count
//   busy        out  registered, 1 in RUN or HOLD
//   done        out  registered one-cycle terminal-count pulse
// -----------------------------------------------------------------------------
module down_timer #(
    parameter int WIDTH   = 16,
    parameter int PRE_DIV = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] load_val,
    input  logic             start,
    input  logic             pause,
    input  logic             abort,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ARMED = 2'b01,
        RUN   = 2'b10,
        HOLD  = 2'b11
    } state_t;

    state_t      state;
    logic [15:0] pre;
    logic        tick;
    logic        load_acc;
    logic        wrap;
    logic [WIDTH-1:0] reload_val;

    assign load_ready = (state == IDLE) || (state == ARMED);
    assign load_acc   = load_valid && load_ready;

    // With PRE_DIV=1 every running cycle is a tick; the prescaler then
    // stays at 0 and is optimised away.
    generate
        if (PRE_DIV == 1) begin : g_nodiv
            assign tick = 1'b1;
        end else begin : g_div
            assign tick = (pre == 16'(PRE_DIV - 1));
        end
    endgenerate

`ifdef DOWN_TIMER_RELOAD_EN
    // Reload register survives abort; only reset clears it.
    logic [WIDTH-1:0] reload;
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            reload <= '0;
        else if (load_acc)
            reload <= load_val;
    end
    assign reload_val = reload;
    assign wrap       = (reload != '0);
`else
    assign reload_val = '0;
    assign wrap       = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            count <= '0;
            pre   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            if (abort) begin
                // Abort wins over everything, including a due terminal count.
                state <= IDLE;
                count <= '0;
                pre   <= '0;
                busy  <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (load_acc) begin
                            count <= load_val;
                            state <= ARMED;
                        end
                    end
                    ARMED: begin
                        if (load_acc)
                            count <= load_val;
                        if (start) begin
                            state <= RUN;
                            pre   <= '0;
                            busy  <= 1'b1;
                        end
                    end
                    RUN, HOLD: begin
                        // HOLD only freezes while pause is high; the edge that
                        // sees pause released does normal RUN work, so the
                        // added latency equals the number of paused edges.
                        if (pause) begin
                            state <= HOLD;
                        end else begin
                            state <= RUN;
                            if (count == '0) begin
                                // Zero load: finish at once, never wrap.
                                done  <= 1'b1;
                                busy  <= 1'b0;
                                pre   <= '0;
                                state <= IDLE;
                            end else if (tick) begin
                                pre <= '0;
                                if (count == WIDTH'(1)) begin
                                    done <= 1'b1;
                                    if (wrap) begin
                                        count <= reload_val;
                                    end else begin
                                        count <= '0;
                                        busy  <= 1'b0;
                                        state <= IDLE;
                                    end
                                end else begin
                                    count <= count - WIDTH'(1);
                                end
                            end else begin
                                pre <= pre + 16'd1;
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_down_timer.sv
// -----------------------------------------------------------------------------
// tb_down_timer
//   Scoreboard bench for down_timer. Two instances share clk/rst: u_a with
//   PRE_DIV=1 and u_b with PRE_DIV=4. Stimulus pushes the expected done event
//   (cycle, count, busy) into a per-instance queue; a negedge monitor pops and
//   compares whenever done is seen. Cycle-level count/busy checks are inline.
// -----------------------------------------------------------------------------
module tb_down_timer;

    typedef struct {
        int          cyc;
        logic [15:0] cnt;
        logic        bsy;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        a_load_valid = 0, a_start = 0, a_pause = 0, a_abort = 0;
    logic [15:0] a_load_val = '0;
    logic        a_load_ready, a_busy, a_done;
    logic [15:0] a_count;

    logic        b_load_valid = 0, b_start = 0, b_pause = 0, b_abort = 0;
    logic [15:0] b_load_val = '0;
    logic        b_load_ready, b_busy, b_done;
    logic [15:0] b_count;

    exp_t qa[$];
    exp_t qb[$];
    int   cyc   = 0;
    int   tests = 0;
    int   fails = 0;
    int   s;

    down_timer #(.WIDTH(16), .PRE_DIV(1)) u_a (
        .clk(clk), .rst(rst), .load_valid(a_load_valid), .load_ready(a_load_ready),
        .load_val(a_load_val), .start(a_start), .pause(a_pause), .abort(a_abort),
        .count(a_count), .busy(a_busy), .done(a_done));

    down_timer #(.WIDTH(16), .PRE_DIV(4)) u_b (
        .clk(clk), .rst(rst), .load_valid(b_load_valid), .load_ready(b_load_ready),
        .load_val(b_load_val), .start(b_start), .pause(b_pause), .abort(b_abort),
        .count(b_count), .busy(b_busy), .done(b_done));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: every done pulse must match the head of the scoreboard.
    always @(negedge clk) begin
        exp_t e;
        if (a_done) begin
            if (qa.size() == 0) chk("a_spurious_done", 32'(a_done), 32'd0);
            else begin
                e = qa.pop_front();
                chk("a_done_cyc", cyc, e.cyc);
                chk("a_done_count", 32'(a_count), 32'(e.cnt));
                chk("a_done_busy", 32'(a_busy), 32'(e.bsy));
            end
        end
        if (b_done) begin
            if (qb.size() == 0) chk("b_spurious_done", 32'(b_done), 32'd0);
            else begin
                e = qb.pop_front();
                chk("b_done_cyc", cyc, e.cyc);
                chk("b_done_count", 32'(b_count), 32'(e.cnt));
                chk("b_done_busy", 32'(b_busy), 32'(e.bsy));
            end
        end
    end

    initial begin
        // Reset state
        step(2);
        chk("rst_count", 32'(a_count), 32'd0);
        chk("rst_busy", 32'(a_busy), 32'd0);
        chk("rst_done", 32'(a_done), 32'd0);
        chk("rst_load_ready", 32'(a_load_ready), 32'd1);
        rst = 1'b0;
        step(1);

        // T1: async reset while running
        a_load_valid = 1; a_load_val = 16'h0123;
        step(1);
        a_load_valid = 0; a_start = 1;
        step(1);
        a_start = 0;
        step(2);
        chk("t1_count_pre", 32'(a_count), 32'h0121);
        #2 rst = 1'b1;
        #1;
        chk("t1_async_count", 32'(a_count), 32'd0);
        chk("t1_async_busy", 32'(a_busy), 32'd0);
        chk("t1_async_done", 32'(a_done), 32'd0);
        step(1);
        rst = 1'b0;
        step(1);

`ifndef DOWN_TIMER_RELOAD_EN
        // T2: PRE_DIV=1, load 3 -> 3,2,1,0 with done on the 0 cycle
        a_load_valid = 1; a_load_val = 16'h0003;
        step(1);
        a_load_valid = 0;
        chk("t2_armed_count", 32'(a_count), 32'd3);
        chk("t2_armed_ready", 32'(a_load_ready), 32'd1);
        a_start = 1; s = cyc;
        qa.push_back('{s + 4, 16'h0000, 1'b0});
        step(1);
        a_start = 0;
        chk("t2_c3", 32'(a_count), 32'd3);
        chk("t2_busy", 32'(a_busy), 32'd1);
        chk("t2_ready_run", 32'(a_load_ready), 32'd0);
        step(1); chk("t2_c2", 32'(a_count), 32'd2);
        step(1); chk("t2_c1", 32'(a_count), 32'd1);
        step(1); chk("t2_c0", 32'(a_count), 32'd0);
        chk("t2_done_hi", 32'(a_done), 32'd1);
        chk("t2_busy_lo", 32'(a_busy), 32'd0);
        chk("t2_idle_ready", 32'(a_load_ready), 32'd1);
        step(1); chk("t2_done_lo", 32'(a_done), 32'd0);

        // T3a: PRE_DIV=4, load 1, no pause -> done 5 edges after start edge
        b_load_valid = 1; b_load_val = 16'h0001;
        step(1);
        b_load_valid = 0; b_start = 1; s = cyc;
        qb.push_back('{s + 5, 16'h0000, 1'b0});
        step(1);
        b_start = 0;
        step(5);

        // T3b: PRE_DIV=4, load 2, pause 6 edges after first tick
        b_load_valid = 1; b_load_val = 16'h0002;
        step(1);
        b_load_valid = 0; b_start = 1; s = cyc;
        qb.push_back('{s + 15, 16'h0000, 1'b0});  // 6 later than s+9
        step(1);
        b_start = 0;
        step(3);
        chk("t3_count_before_tick", 32'(b_count), 32'd2);
        step(1);
        chk("t3_count_after_tick", 32'(b_count), 32'd1);
        b_pause = 1;
        step(3);
        chk("t3_hold_count", 32'(b_count), 32'd1);
        chk("t3_hold_busy", 32'(b_busy), 32'd1);
        step(3);
        chk("t3_hold_count_end", 32'(b_count), 32'd1);
        b_pause = 0;
        step(3);
        chk("t3_count_resumed", 32'(b_count), 32'd1);
        step(2);
`endif

        // T4: zero load -> single done, no wrap; load during RUN ignored
        a_load_valid = 1; a_load_val = 16'h0000;
        step(1);
        a_load_valid = 0; a_start = 1; s = cyc;
        qa.push_back('{s + 2, 16'h0000, 1'b0});
        step(1);
        a_start = 0;
        a_load_valid = 1; a_load_val = 16'h0055;
        chk("t4_ready_run", 32'(a_load_ready), 32'd0);
        step(1);
        a_load_valid = 0;
        chk("t4_count_zero", 32'(a_count), 32'd0);
        step(3);
        chk("t4_no_wrap", 32'(a_count), 32'd0);

        // T5: abort on the edge where count==1 and a tick is due
        a_load_valid = 1; a_load_val = 16'h0002;
        step(1);
        a_load_valid = 0; a_start = 1;
        step(1);
        a_start = 0;
        step(1);
        chk("t5_count1", 32'(a_count), 32'd1);
        a_abort = 1;
        step(1);
        a_abort = 0;
        chk("t5_count", 32'(a_count), 32'd0);
        chk("t5_done", 32'(a_done), 32'd0);
        chk("t5_busy", 32'(a_busy), 32'd0);
        chk("t5_idle", 32'(a_load_ready), 32'd1);
        step(2);

`ifdef DOWN_TIMER_RELOAD_EN
        // T6: periodic reload, count 2,1,2,1 with done each period
        a_load_valid = 1; a_load_val = 16'h0002;
        step(1);
        a_load_valid = 0; a_start = 1; s = cyc;
        qa.push_back('{s + 3, 16'h0002, 1'b1});
        qa.push_back('{s + 5, 16'h0002, 1'b1});
        step(1);
        a_start = 0;
        chk("t6_c2", 32'(a_count), 32'd2);
        step(1); chk("t6_c1", 32'(a_count), 32'd1);
        step(1); chk("t6_reload", 32'(a_count), 32'd2);
        chk("t6_busy", 32'(a_busy), 32'd1);
        step(2);
        a_abort = 1;
        step(1);
        a_abort = 0;
        chk("t6_abort_count", 32'(a_count), 32'd0);
        chk("t6_abort_busy", 32'(a_busy), 32'd0);
        chk("t6_abort_idle", 32'(a_load_ready), 32'd1);
        step(2);
`endif

        step(3);
        chk("a_pending_done", qa.size(), 32'd0);
        chk("b_pending_done", qb.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
